// File: rtl/hsi_pkg.sv
// Shared HSI definitions: CCW buffer size/retry defaults and the buffer state encoding.
package hsi_pkg;

   localparam int CCW_MAX_LEN    = 32;
   localparam int CCW_MAX_REPEAT = 3;

   typedef enum logic [1:0] {
      FILL,
      READY,
      SEND,
      WAIT_ACK
   } ccw_buf_state_t;

endpackage

// File: rtl/ccw_mem.sv
// CCW frame storage: MAX_LEN x 8 register array, synchronous write, registered read.
module ccw_mem
   import hsi_pkg::*;
#(
   parameter int  MAX_LEN = CCW_MAX_LEN,
   localparam int PW      = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_wr_en,
   input  logic [PW-1:0] i_wr_addr,
   input  logic [7:0]    i_wr_data,
   input  logic          i_rd_en,
   input  logic [PW-1:0] i_rd_addr,
   output logic [7:0]    o_rd_data
);

   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   logic [7:0] r_mem [MAX_LEN];
   logic [7:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en && (i_wr_addr < PW'(MAX_LEN))) begin
         r_mem[i_wr_addr[AW-1:0]] <= i_wr_data;
      end
   end

   // Read data only moves when asked, so the output byte holds between acks.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data <= '0;
      end else if (i_rd_en && (i_rd_addr < PW'(MAX_LEN))) begin
         r_rd_data <= r_mem[i_rd_addr[AW-1:0]];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ccw_buffer.sv
// Single-frame CCW buffer: fills from the host, streams to hsi_master with bounded retransmission.
module ccw_buffer
   import hsi_pkg::*;
#(
   parameter int MAX_LEN    = CCW_MAX_LEN,
   parameter int MAX_REPEAT = CCW_MAX_REPEAT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] wr_d,
   input  logic       wr_en,
   input  logic       wr_last,
   output logic       wr_busy,
   output logic       ovf_err,
   output logic       ccw_tx_rdy,
   input  logic       ccw_tx_en,
   output logic [7:0] ccw_d,
   output logic       ccw_d_rdy,
   input  logic       ccw_d_ack,
   output logic       ccw_d_sending,
   input  logic       ccw_repeat_req,
   input  logic       ccw_accepted,
   output logic       ccw_done,
   output logic       ccw_fail
);

   localparam int PW = $clog2(MAX_LEN + 1);
   localparam int RW = (MAX_REPEAT > 0) ? $clog2(MAX_REPEAT + 1) : 1;

   ccw_buf_state_t r_state;
   logic [PW-1:0]  r_wptr;
   logic [PW-1:0]  r_rptr;
   logic [PW-1:0]  r_len;
   logic [RW-1:0]  r_rpt_cnt;
   logic           r_ovf;
   logic           r_wr_busy;
   logic           r_ovf_err;
   logic           r_tx_rdy;
   logic           r_d_rdy;
   logic           r_sending;
   logic           r_done;
   logic           r_fail;

   logic [PW-1:0]  w_wptr_inc;
   logic [PW-1:0]  w_rptr_inc;
   logic           w_mem_wr;
   logic           w_ack;
   logic           w_rd_en;
   logic [PW-1:0]  w_rd_addr;

   assign w_wptr_inc = r_wptr + PW'(1);
   assign w_rptr_inc = r_rptr + PW'(1);
   assign w_mem_wr   = (r_state == FILL) && wr_en && !r_ovf;

   // Accepted and repeat both pre-empt an ack landing in the same cycle.
   assign w_ack = (r_state == SEND) && ccw_d_ack && r_d_rdy
                  && !ccw_accepted && !ccw_repeat_req;

   // Prefetch: the next byte's address goes to memory on the ack itself.
   assign w_rd_en   = ((r_state == READY) && ccw_tx_en) || (w_ack && (w_rptr_inc < r_len));
   assign w_rd_addr = (r_state == READY) ? '0 : w_rptr_inc;

   ccw_mem #(
      .MAX_LEN (MAX_LEN)
   ) u_mem (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_mem_wr),
      .i_wr_addr (r_wptr),
      .i_wr_data (wr_d),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (ccw_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= FILL;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_len     <= '0;
         r_rpt_cnt <= '0;
         r_ovf     <= 1'b0;
         r_wr_busy <= 1'b0;
         r_ovf_err <= 1'b0;
         r_tx_rdy  <= 1'b0;
         r_d_rdy   <= 1'b0;
         r_sending <= 1'b0;
         r_done    <= 1'b0;
         r_fail    <= 1'b0;
      end else begin
         r_ovf_err <= 1'b0;
         r_done    <= 1'b0;
         r_fail    <= 1'b0;
         case (r_state)
            FILL: begin
               if (wr_en) begin
                  if (r_ovf) begin
                     // An oversized frame is swallowed up to its last byte, then dropped.
                     if (wr_last) begin
                        r_ovf_err <= 1'b1;
                        r_ovf     <= 1'b0;
                        r_wptr    <= '0;
                     end
                  end else if (wr_last) begin
                     r_wptr    <= w_wptr_inc;
                     r_len     <= w_wptr_inc;
                     r_state   <= READY;
                     r_tx_rdy  <= 1'b1;
                     r_wr_busy <= 1'b1;
                  end else begin
                     r_wptr <= w_wptr_inc;
                     if (r_wptr == PW'(MAX_LEN - 1)) begin
                        r_ovf <= 1'b1;
                     end
                  end
               end
            end
            READY: begin
               if (ccw_tx_en) begin
                  r_state   <= SEND;
                  r_rptr    <= '0;
                  r_tx_rdy  <= 1'b0;
                  r_sending <= 1'b1;
                  r_d_rdy   <= 1'b1;
               end
            end
            SEND, WAIT_ACK: begin
               if (ccw_accepted) begin
                  r_done    <= 1'b1;
                  r_rpt_cnt <= '0;
                  r_wptr    <= '0;
                  r_state   <= FILL;
                  r_wr_busy <= 1'b0;
                  r_sending <= 1'b0;
                  r_d_rdy   <= 1'b0;
               end else if (ccw_repeat_req) begin
                  r_sending <= 1'b0;
                  r_d_rdy   <= 1'b0;
                  if (r_rpt_cnt < RW'(MAX_REPEAT)) begin
                     r_rpt_cnt <= r_rpt_cnt + RW'(1);
                     r_rptr    <= '0;
                     r_state   <= READY;
                     r_tx_rdy  <= 1'b1;
                  end else begin
                     r_fail    <= 1'b1;
                     r_rpt_cnt <= '0;
                     r_wptr    <= '0;
                     r_state   <= FILL;
                     r_wr_busy <= 1'b0;
                  end
               end else if (w_ack) begin
                  r_rptr <= w_rptr_inc;
                  if (w_rptr_inc == r_len) begin
                     r_state   <= WAIT_ACK;
                     r_d_rdy   <= 1'b0;
                     r_sending <= 1'b0;
                  end
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end

   assign wr_busy       = r_wr_busy;
   assign ovf_err       = r_ovf_err;
   assign ccw_tx_rdy    = r_tx_rdy;
   assign ccw_d_rdy     = r_d_rdy;
   assign ccw_d_sending = r_sending;
   assign ccw_done      = r_done;
   assign ccw_fail      = r_fail;

endmodule
